// File: rtl/uart_pkg.sv
// Shared UART types and helpers: transmitter state encoding, data width, baud divisor rounding.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [2:0] {
    TxIdle   = 3'd0,
    TxStart  = 3'd1,
    TxData   = 3'd2,
    TxParity = 3'd3,
    TxStop   = 3'd4
  } tx_state_t;

  // Divisor rounded to nearest so the bit time error stays under half a clock.
  function automatic int unsigned calc_divisor(input int unsigned clk_freq,
                                               input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO with wrap-bit pointers; head is visible combinationally (no read latency).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [UART_DATA_W-1:0] wdata_i,
  input  logic                   pop_i,
  output logic [UART_DATA_W-1:0] rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [AW:0]            count_o
);

  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]            wptr_q, wptr_d;
  logic [AW:0]            rptr_q, rptr_d;
  logic                   do_push, do_pop;

  // Same index with differing wrap bits means the write pointer has lapped the read pointer.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PtrOne;
    if (do_pop)  rptr_d = rptr_q + PtrOne;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: TX FIFO, baud divider, framing FSM and registered tx line.
// Define UART_PARITY_EN for 8E1 framing (even parity bit between data and stop); default is 8N1.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned UART_BAUD  = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [UART_DATA_W-1:0]        wr_data_i,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          tx_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned Divisor = calc_divisor(CLK_FREQ, UART_BAUD);
  localparam int unsigned CntW    = (Divisor > 1) ? $clog2(Divisor) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Divisor - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [2:0]      LastBit = 3'(UART_DATA_W - 1);

  localparam logic [2:0] StIdle   = 3'(TxIdle);
  localparam logic [2:0] StStart  = 3'(TxStart);
  localparam logic [2:0] StData   = 3'(TxData);
  localparam logic [2:0] StStop   = 3'(TxStop);
`ifdef UART_PARITY_EN
  localparam logic [2:0] StParity = 3'(TxParity);
`endif

  logic [2:0]             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   bit_end;
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [UART_DATA_W-1:0] fifo_rdata;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (wr_valid_i),
    .wdata_i (wr_data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  assign bit_end = (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    fifo_pop  = 1'b0;
    if (state_q != StIdle) cnt_d = bit_end ? '0 : cnt_q + CntOne;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cnt_d    = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LastBit) begin
`ifdef UART_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_end) begin
          done_d = 1'b1;
          // Chain straight into the next start bit so back-to-back frames have no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = StStart;
          end else begin
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (fifo_pop) shift_d = fifo_rdata;
  end

`ifdef UART_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      parity_q <= 1'b0;
    end else if (fifo_pop) begin
      parity_q <= ^fifo_rdata;
    end
  end
`endif

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_q[0];
`ifdef UART_PARITY_EN
      StParity: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign tx_o       = tx_q;
  assign tx_done_o  = done_q;
  assign busy_o     = (state_q != StIdle);
  assign wr_ready_o = !fifo_full;

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: driver queues expected bytes, a line monitor decodes tx frames.
module tb_uart_tx_core;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 57_000;
  localparam int unsigned DEPTH    = 16;
  localparam int D = (CLK_FREQ + BAUD / 2) / BAUD;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready, tx, busy, tx_done;
  logic [4:0] fifo_count;

  uart_tx_core #(
    .CLK_FREQ   (CLK_FREQ),
    .UART_BAUD  (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_data_i    (wr_data),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready),
    .tx_o         (tx),
    .busy_o       (busy),
    .tx_done_o    (tx_done),
    .fifo_count_o (fifo_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rst_edge = 1'b1;
  logic [7:0] exp_q[$];
  int   frames_done = 0;
  int   done_cycles = 0;
  logic saw_full = 1'b0;
  logic busy_prev = 1'b0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line monitor: frame k-th bit is sampled mid-bit; tx_done must fire on the frame's last cycle.
  logic          mon_active = 1'b0;
  int            mon_c = 0;
  int            off;
  logic [NB-1:0] mon_bits;
  logic [7:0]    exp_b;

  initial forever begin
    @(negedge clk);
    if (rst_edge) begin
      mon_active = 1'b0;
    end else begin
      if (tx_done === 1'b1) done_cycles++;
      if (busy && !busy_prev) rise_cyc = cyc;
      if (!busy && busy_prev) fall_cyc = cyc;
      busy_prev = busy;
      if (!mon_active && tx === 1'b0) begin
        mon_active = 1'b1;
        mon_c      = cyc;
      end
      if (mon_active) begin
        off = cyc - mon_c;
        if (off % D == D / 2) mon_bits[off / D] = tx;
        if (off == (NB - 1) * D + D / 2) begin
          check("start bit", {31'd0, mon_bits[0]}, 32'd0);
          check("stop bit", {31'd0, mon_bits[NB-1]}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame: got unexpected byte %0h expected none", mon_bits[8:1]);
          end else begin
            exp_b = exp_q.pop_front();
            check("frame byte", {24'd0, mon_bits[8:1]}, {24'd0, exp_b});
`ifdef UART_PARITY_EN
            check("parity bit", {31'd0, mon_bits[9]}, {31'd0, ^exp_b});
`endif
          end
        end
        if (off == NB * D - 1) begin
          check("tx_done at frame end", {31'd0, tx_done}, 32'd1);
          mon_active = 1'b0;
          frames_done++;
        end else begin
          check("tx_done inside frame", {31'd0, tx_done}, 32'd0);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [7:0] b);
    int waited = 0;
    wr_valid = 1'b1;
    wr_data  = b;
    if (wr_ready !== 1'b1) begin
      saw_full = 1'b1;
      check("count when not ready", {27'd0, fifo_count}, DEPTH);
    end
    while (wr_ready !== 1'b1) begin
      @(negedge clk);
      waited++;
      if (waited > 4 * NB * D) begin
        checks++;
        errors++;
        $display("FAIL push: got wr_ready %b expected 1 within %0d cycles", wr_ready, 4 * NB * D);
        wr_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(b);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int waited = 0;
    while (busy !== 1'b0 || fifo_count !== 5'd0 || mon_active) begin
      @(negedge clk);
      waited++;
      if (waited > 40 * NB * D) begin
        checks++;
        errors++;
        $display("FAIL idle: got busy %b count %0d expected idle", busy, fifo_count);
        return;
      end
    end
    check("scoreboard drained", exp_q.size(), 0);
  endtask

  initial begin
    string s;
    int    waited;
    logic  line_low;
    s = "Hello World!\n";

    repeat (3) @(negedge clk);
    check("reset tx", {31'd0, tx}, 32'd1);
    check("reset wr_ready", {31'd0, wr_ready}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset tx_done", {31'd0, tx_done}, 32'd0);
    check("reset fifo_count", {27'd0, fifo_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte: pop one edge after the push, start bit one edge after that.
    push(8'h48);
    wr_valid = 1'b0;
    check("count after push", {27'd0, fifo_count}, 32'd1);
    check("busy before pop", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("busy after pop", {31'd0, busy}, 32'd1);
    check("count after pop", {27'd0, fifo_count}, 32'd0);
    check("tx before start", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("tx start bit edge", {31'd0, tx}, 32'd0);
    wait_idle();

    // Simultaneous push and pop at count 1.
    push(8'h3C);
    push(8'hC3);
    wr_valid = 1'b0;
    check("count push+pop", {27'd0, fifo_count}, 32'd1);
    wait_idle();

    // Contiguous burst; busy spans exactly 13 frames.
    saw_full = 1'b0;
    for (int i = 0; i < s.len(); i++) push(s[i]);
    wr_valid = 1'b0;
    check("burst never full", {31'd0, saw_full}, 32'd0);
    wait_idle();
    check("burst busy span", fall_cyc - rise_cyc, s.len() * NB * D);

    // Overfill with valid held high.
    saw_full = 1'b0;
    for (int i = 0; i < 20; i++) push(8'($urandom_range(0, 255)));
    wr_valid = 1'b0;
    check("overfill saw full", {31'd0, saw_full}, 32'd1);
    wait_idle();

    // Reset during data bit 3 of 0xA5 with 5 more bytes queued.
    push(8'hA5);
    for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)));
    wr_valid = 1'b0;
    waited = 0;
    while (tx !== 1'b0 && waited < 4 * NB * D) begin
      @(negedge clk);
      waited++;
    end
    repeat (4 * D + D / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("mid reset tx", {31'd0, tx}, 32'd1);
    check("mid reset count", {27'd0, fifo_count}, 32'd0);
    check("mid reset busy", {31'd0, busy}, 32'd0);
    check("mid reset tx_done", {31'd0, tx_done}, 32'd0);
    line_low = 1'b0;
    repeat (3 * NB * D) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_done !== 1'b0) line_low = 1'b1;
    end
    check("line idle after reset", {31'd0, line_low}, 32'd0);

    // Parity-relevant pair, then randomized traffic with random gaps.
    push(8'h07);
    push(8'h03);
    wr_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 15; i++) begin
      push(8'($urandom_range(0, 255)));
      wr_valid = 1'b0;
      repeat ($urandom_range(0, NB * D)) @(negedge clk);
    end
    wait_idle();

    check("tx_done cycles vs frames", done_cycles, frames_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(60_000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
